pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the processor fetch stage, successor of the single-width PC register. Holds the current fetch address and its sequential successor, applies jump/call/return redirects, and keeps an optional hardware return-address stack (RAS). Stall no longer drops redirects: a redirect arriving while stalled is latched and applied on release.

## Interface
- AW, 32: address width in bits.
- STEP, 1: sequential increment (word addressing by default).
- RESET_VEC, 0: value of pc_cur after reset.
- RAS_DEPTH, 4: RAS entries (≥2); counter width $clog2(RAS_DEPTH+1).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- halt  in  1  freeze all state; all other inputs ignored.
- stall  in  1  hold pc_cur; redirects latched as pending.
- jump_vld  in  1  redirect to tgt.
- call_vld  in  1  redirect to tgt, push pc_seq onto RAS.
- ret_vld  in  1  redirect to popped RAS entry.
- tgt  in  AW  jump/call target.
- pc_cur  out  AW  current fetch address.
- pc_seq  out  AW  pc_cur + STEP, registered.
- pend_vld  out  1  a redirect is latched awaiting stall release.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky: push while full occurred.
- ras_unf  out  1  sticky: pop while empty occurred.

## Operation
- Reset (async): pc_cur=RESET_VEC, pc_seq=RESET_VEC+STEP, pend_vld=0, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
- Per-edge priority: halt > stall > new event > pending > sequential.
- Event select when several valid: ret > call > jump; lower ones discarded.
- Advance (not halted, not stalled): next = event target, else pending target, else pc_seq; pc_cur<=next, pc_seq<=next+STEP. A new event clears and drops any pending one.
- Stall: pc_cur, pc_seq held. A valid event is captured into pending (type + tgt); a later event during the same stall overwrites it (last wins). RAS untouched until the event is applied.
- Halt: no register changes, including pending and RAS.
- Call applied: push pc_seq (the value at apply time). Full: overwrite oldest entry (circular), count stays RAS_DEPTH, set ras_ovf.
- Ret applied: target = top entry, pop. Empty: target = RESET_VEC, count stays 0, set ras_unf.
- Arithmetic modulo 2^AW; pc_cur = 2^AW−STEP wraps pc_seq to 0 without error.
- Sticky flags clear only on reset.

## Timing
- Event sampled on edge N (unstalled) -> pc_cur=target after edge N; pc_seq=target+STEP same edge.
- Event during stall -> pend_vld=1 after that edge; first edge with stall=0 applies it, pend_vld=0 after that edge.
- RAS flags/count update on the same edge the call/ret is applied.
- No combinational input-to-output paths.

## Configuration
- PC_RAS_EN defined: RAS, ras_* flags as above.
- Not defined: no stack storage; call_vld behaves as jump_vld; ret_vld jumps to tgt; ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0 constant. Pending and priority rules unchanged.

## Structure
- Package pc_seq_pkg: event-type enum (EV_NONE, EV_JUMP, EV_CALL, EV_RET), default parameter constants.
- One sub-module pc_ras: circular LIFO with push/pop/top, count, full/empty, ovf/unf pulses; instantiated only under PC_RAS_EN.

## Test plan
- Reset mid-run with RESET_VEC=0x100, STEP=4 -> pc_cur=0x100, pc_seq=0x104 immediately, flags 0; three free edges -> pc_cur=0x10C.
- Unstalled jump_vld tgt=0x40 at pc_cur=0x08 -> next edge pc_cur=0x40, pc_seq=0x41; halt held 3 cycles with jump_vld asserted -> no change.
- Stall 3 cycles, jump tgt=0x20 then jump tgt=0x30 during stall -> pend_vld=1, pc_cur held; release -> pc_cur=0x30, pend_vld=0; release with simultaneous jump tgt=0x50 -> pc_cur=0x50.
- RAS_DEPTH=2: call 0x10 at pc 0x0, call 0x20 at pc 0x10, call 0x30 at pc 0x20 -> ras_ovf=1, ras_full=1; three rets -> pc_cur 0x21, 0x11, then RESET_VEC with ras_unf=1.
- AW=8, STEP=1, pc_cur=0xFF -> pc_seq=0x00; next edge pc_cur=0x00, no flags.
- Build without PC_RAS_EN: call tgt=0x80 then ret tgt=0x90 -> pc_cur 0x80 then 0x90, ras_empty stays 1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
// The optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_JUMP = 2'd1,
        EV_CALL = 2'd2,
        EV_RET  = 2'd3
    } ev_type_e;

    localparam int unsigned PC_AW_DEF        = 32'd32;
    localparam int unsigned PC_STEP_DEF      = 32'd1;
    localparam int unsigned PC_RESET_VEC_DEF = 32'd0;
    localparam int unsigned PC_RAS_DEPTH_DEF = 32'd4;

    // When several redirects are valid together, ret beats call beats jump.
    function automatic ev_type_e ev_select(input logic jump, input logic call, input logic ret);
        ev_type_e ev;
        if (ret) begin
            ev = EV_RET;
        end else if (call) begin
            ev = EV_CALL;
        end else if (jump) begin
            ev = EV_JUMP;
        end else begin
            ev = EV_NONE;
        end
        return ev;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/top with saturating count.
// A push while full overwrites the oldest entry; a pop while empty changes nothing.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned DW    = PC_AW_DEF,
    parameter int unsigned DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] top_data,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int unsigned PW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam int unsigned CW = $clog2(DEPTH + 32'd1);
    localparam logic [PW-1:0] last_idx_c = PW'(DEPTH - 32'd1);
    localparam logic [CW-1:0] depth_c    = CW'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] top_ptr_s;
    logic [PW-1:0] inc_ptr_s;
    logic [CW-1:0] count_r;
    logic          empty_r;
    logic          full_r;

    // Pointer neighbours with explicit wrap so non-power-of-two depths work.
    always_comb begin
        top_ptr_s = wr_ptr_r;
        inc_ptr_s = wr_ptr_r;
        if (wr_ptr_r == {PW{1'b0}}) begin
            top_ptr_s = last_idx_c;
        end else begin
            top_ptr_s = wr_ptr_r - PW'(1'b1);
        end
        if (wr_ptr_r == last_idx_c) begin
            inc_ptr_s = {PW{1'b0}};
        end else begin
            inc_ptr_s = wr_ptr_r + PW'(1'b1);
        end
    end

    assign top_data = mem_r[top_ptr_s];
    assign empty    = empty_r;
    assign full     = full_r;
    assign ovf      = push & full_r;
    assign unf      = pop & empty_r;

    // Stack storage, write pointer, count and registered full/empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= inc_ptr_s;
            if (!full_r) begin
                count_r <= count_r + CW'(1'b1);
                empty_r <= 1'b0;
                full_r  <= ((count_r + CW'(1'b1)) == depth_c);
            end
        end else if (pop && !empty_r) begin
            wr_ptr_r <= top_ptr_s;
            count_r  <= count_r - CW'(1'b1);
            full_r   <= 1'b0;
            empty_r  <= (count_r == CW'(1'b1));
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with jump/call/return redirects and stall-time pending latch.
// Define PC_RAS_EN to build the hardware return-address stack; otherwise call/ret act as jumps.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned   AW        = PC_AW_DEF,
    parameter int unsigned   STEP      = PC_STEP_DEF,
    parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC_DEF),
    parameter int unsigned   RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          halt,
    input  logic          stall,
    input  logic          jump_vld,
    input  logic          call_vld,
    input  logic          ret_vld,
    input  logic [AW-1:0] tgt,
    output logic [AW-1:0] pc_cur,
    output logic [AW-1:0] pc_seq,
    output logic          pend_vld,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_unf
);

    localparam logic [AW-1:0] step_c = AW'(STEP);

    logic [AW-1:0] pc_cur_r;
    logic [AW-1:0] pc_seq_r;
    logic          pend_vld_r;
    ev_type_e      pend_type_r;
    logic [AW-1:0] pend_tgt_r;

    ev_type_e      ev_s;
    ev_type_e      apply_type_s;
    logic [AW-1:0] apply_tgt_s;
    logic [AW-1:0] ret_tgt_s;
    logic [AW-1:0] next_s;
    logic          advance_s;

    assign ev_s      = ev_select(jump_vld, call_vld, ret_vld);
    assign advance_s = ~halt & ~stall;

    // A fresh event overrides whatever was latched during the stall.
    always_comb begin
        apply_type_s = EV_NONE;
        apply_tgt_s  = pc_seq_r;
        if (ev_s != EV_NONE) begin
            apply_type_s = ev_s;
            apply_tgt_s  = tgt;
        end else if (pend_vld_r) begin
            apply_type_s = pend_type_r;
            apply_tgt_s  = pend_tgt_r;
        end else begin
            apply_type_s = EV_NONE;
            apply_tgt_s  = pc_seq_r;
        end
    end

`ifdef PC_RAS_EN
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] ras_top_s;
    logic          ras_empty_s;
    logic          ras_full_s;
    logic          ras_ovf_s;
    logic          ras_unf_s;
    logic          ras_ovf_r;
    logic          ras_unf_r;

    assign push_s = advance_s & (apply_type_s == EV_CALL);
    assign pop_s  = advance_s & (apply_type_s == EV_RET);

    pc_ras #(
        .DW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_seq_r),
        .top_data  (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full_s),
        .ovf       (ras_ovf_s),
        .unf       (ras_unf_s)
    );

    // Returning from an empty stack falls back to the reset vector.
    always_comb begin
        if (ras_empty_s) begin
            ret_tgt_s = RESET_VEC;
        end else begin
            ret_tgt_s = ras_top_s;
        end
    end

    // Sticky stack-error flags, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ras_ovf_r <= 1'b0;
            ras_unf_r <= 1'b0;
        end else begin
            ras_ovf_r <= ras_ovf_r | ras_ovf_s;
            ras_unf_r <= ras_unf_r | ras_unf_s;
        end
    end

    assign ras_empty = ras_empty_s;
    assign ras_full  = ras_full_s;
    assign ras_ovf   = ras_ovf_r;
    assign ras_unf   = ras_unf_r;
`else
    // Without a stack a return simply jumps to its target.
    always_comb begin
        ret_tgt_s = apply_tgt_s;
    end

    // No storage: the count is pinned at zero.
    assign ras_empty = 1'b1;
    assign ras_full  = (RAS_DEPTH == 32'd0);
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    // Next fetch address for an unstalled edge.
    always_comb begin
        next_s = pc_seq_r;
        case (apply_type_s)
            EV_JUMP, EV_CALL: next_s = apply_tgt_s;
            EV_RET:           next_s = ret_tgt_s;
            default:          next_s = pc_seq_r;
        endcase
    end

    // PC pair and pending-redirect latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_cur_r    <= RESET_VEC;
            pc_seq_r    <= RESET_VEC + step_c;
            pend_vld_r  <= 1'b0;
            pend_type_r <= EV_NONE;
            pend_tgt_r  <= {AW{1'b0}};
        end else if (halt) begin
            pc_cur_r    <= pc_cur_r;
            pc_seq_r    <= pc_seq_r;
            pend_vld_r  <= pend_vld_r;
            pend_type_r <= pend_type_r;
            pend_tgt_r  <= pend_tgt_r;
        end else if (stall) begin
            if (ev_s != EV_NONE) begin
                pend_vld_r  <= 1'b1;
                pend_type_r <= ev_s;
                pend_tgt_r  <= tgt;
            end
        end else begin
            pc_cur_r    <= next_s;
            pc_seq_r    <= next_s + step_c;
            pend_vld_r  <= 1'b0;
            pend_type_r <= EV_NONE;
        end
    end

    assign pc_cur   = pc_cur_r;
    assign pc_seq   = pc_seq_r;
    assign pend_vld = pend_vld_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: one 32-bit word-of-4 instance for reset checks and one 8-bit instance for redirects.
// Expected stack behaviour follows whether PC_RAS_EN is defined for the build.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        halt;
    logic        stall;
    logic        jump_vld;
    logic        call_vld;
    logic        ret_vld;
    logic [31:0] tgt;

    logic [31:0] a_pc_cur, a_pc_seq;
    logic        a_pend, a_empty, a_full, a_ovf, a_unf;
    logic [7:0]  b_pc_cur, b_pc_seq;
    logic        b_pend, b_empty, b_full, b_ovf, b_unf;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .AW(32), .STEP(4), .RESET_VEC(32'h0000_0100), .RAS_DEPTH(2)
    ) u_dut_a (
        .clock(clock), .reset(reset), .halt(halt), .stall(stall),
        .jump_vld(jump_vld), .call_vld(call_vld), .ret_vld(ret_vld), .tgt(tgt),
        .pc_cur(a_pc_cur), .pc_seq(a_pc_seq), .pend_vld(a_pend),
        .ras_empty(a_empty), .ras_full(a_full), .ras_ovf(a_ovf), .ras_unf(a_unf)
    );

    pc_sequencer #(
        .AW(8), .STEP(1), .RESET_VEC(8'h00), .RAS_DEPTH(2)
    ) u_dut_b (
        .clock(clock), .reset(reset), .halt(halt), .stall(stall),
        .jump_vld(jump_vld), .call_vld(call_vld), .ret_vld(ret_vld), .tgt(tgt[7:0]),
        .pc_cur(b_pc_cur), .pc_seq(b_pc_seq), .pend_vld(b_pend),
        .ras_empty(b_empty), .ras_full(b_full), .ras_ovf(b_ovf), .ras_unf(b_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic j, input logic c, input logic r, input logic [31:0] t);
        jump_vld = j;
        call_vld = c;
        ret_vld  = r;
        tgt      = t;
    endtask

    initial begin
        reset = 1'b1;
        halt  = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        check("rst_a_cur",   a_pc_cur, 32'h100);
        check("rst_a_seq",   a_pc_seq, 32'h104);
        check("rst_a_pend",  {31'd0, a_pend},  32'd0);
        check("rst_a_empty", {31'd0, a_empty}, 32'd1);
        check("rst_a_full",  {31'd0, a_full},  32'd0);
        check("rst_a_ovf",   {31'd0, a_ovf},   32'd0);
        check("rst_a_unf",   {31'd0, a_unf},   32'd0);
        check("rst_b_seq",   {24'd0, b_pc_seq}, 32'h01);
        reset = 1'b0;
        tick(3);
        check("free3_a_cur", a_pc_cur, 32'h10C);

        // asynchronous reset in the middle of a cycle
        #2 reset = 1'b1;
        #1;
        check("midrst_a_cur", a_pc_cur, 32'h100);
        check("midrst_a_seq", a_pc_seq, 32'h104);
        reset = 1'b0;
        tick(3);
        check("midrst3_a_cur", a_pc_cur, 32'h10C);
        check("midrst3_a_seq", a_pc_seq, 32'h110);
        check("midrst3_b_cur", {24'd0, b_pc_cur}, 32'h03);

        // unstalled jumps
        drive(1'b1, 1'b0, 1'b0, 32'h08);
        tick(1);
        check("jmp8_b_cur", {24'd0, b_pc_cur}, 32'h08);
        drive(1'b1, 1'b0, 1'b0, 32'h40);
        tick(1);
        check("jmp40_b_cur", {24'd0, b_pc_cur}, 32'h40);
        check("jmp40_b_seq", {24'd0, b_pc_seq}, 32'h41);
        check("jmp40_a_seq", a_pc_seq, 32'h44);

        // halt freezes everything, even with a redirect present
        halt = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h77);
        tick(3);
        check("halt_b_cur",  {24'd0, b_pc_cur}, 32'h40);
        check("halt_b_seq",  {24'd0, b_pc_seq}, 32'h41);
        check("halt_b_pend", {31'd0, b_pend}, 32'd0);
        halt = 1'b0;

        // stall: last redirect wins, applied on release
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h20);
        tick(1);
        check("stl1_b_pend", {31'd0, b_pend}, 32'd1);
        check("stl1_b_cur",  {24'd0, b_pc_cur}, 32'h40);
        drive(1'b1, 1'b0, 1'b0, 32'h30);
        tick(1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1);
        check("stl3_b_cur",  {24'd0, b_pc_cur}, 32'h40);
        check("stl3_b_seq",  {24'd0, b_pc_seq}, 32'h41);
        check("stl3_b_pend", {31'd0, b_pend}, 32'd1);
        stall = 1'b0;
        tick(1);
        check("rel_b_cur",  {24'd0, b_pc_cur}, 32'h30);
        check("rel_b_seq",  {24'd0, b_pc_seq}, 32'h31);
        check("rel_b_pend", {31'd0, b_pend}, 32'd0);

        // a new event at release drops the pending one
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h60);
        tick(1);
        check("stl2_b_pend", {31'd0, b_pend}, 32'd1);
        stall = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h50);
        tick(1);
        check("relnew_b_cur",  {24'd0, b_pc_cur}, 32'h50);
        check("relnew_b_pend", {31'd0, b_pend}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1);
        check("dropped_b_cur", {24'd0, b_pc_cur}, 32'h51);

        // calls into a depth-2 stack: third call overflows
        drive(1'b1, 1'b0, 1'b0, 32'h00);
        tick(1);
        drive(1'b0, 1'b1, 1'b0, 32'h10);
        tick(1);
        drive(1'b0, 1'b1, 1'b0, 32'h20);
        tick(1);
        check("call2_b_cur",  {24'd0, b_pc_cur}, 32'h20);
        check("call2_b_full", {31'd0, b_full}, {31'd0, RAS_ON});
        check("call2_b_ovf",  {31'd0, b_ovf}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h30);
        tick(1);
        check("call3_b_cur",   {24'd0, b_pc_cur}, 32'h30);
        check("call3_b_full",  {31'd0, b_full}, {31'd0, RAS_ON});
        check("call3_b_ovf",   {31'd0, b_ovf},  {31'd0, RAS_ON});
        check("call3_b_empty", {31'd0, b_empty}, {31'd0, ~RAS_ON});

        // returns: newest first, then underflow to the reset vector
        drive(1'b0, 1'b0, 1'b1, 32'h90);
        tick(1);
        check("ret1_b_cur", {24'd0, b_pc_cur}, RAS_ON ? 32'h21 : 32'h90);
        drive(1'b0, 1'b0, 1'b1, 32'h91);
        tick(1);
        check("ret2_b_cur",   {24'd0, b_pc_cur}, RAS_ON ? 32'h11 : 32'h91);
        check("ret2_b_empty", {31'd0, b_empty}, 32'd1);
        check("ret2_b_unf",   {31'd0, b_unf}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h92);
        tick(1);
        check("ret3_b_cur",  {24'd0, b_pc_cur}, RAS_ON ? 32'h00 : 32'h92);
        check("ret3_b_unf",  {31'd0, b_unf},  {31'd0, RAS_ON});
        check("ret3_b_full", {31'd0, b_full}, 32'd0);

        // simultaneous events: call beats jump, ret beats jump
        drive(1'b1, 1'b1, 1'b0, 32'h44);
        tick(1);
        check("prio_call_b_cur",   {24'd0, b_pc_cur}, 32'h44);
        check("prio_call_b_empty", {31'd0, b_empty}, {31'd0, ~RAS_ON});
        drive(1'b1, 1'b0, 1'b1, 32'h55);
        tick(1);
        check("prio_ret_b_cur", {24'd0, b_pc_cur}, RAS_ON ? 32'h01 : 32'h55);

        // address wrap at the top of an 8-bit space
        drive(1'b1, 1'b0, 1'b0, 32'hFF);
        tick(1);
        check("wrap_b_cur", {24'd0, b_pc_cur}, 32'hFF);
        check("wrap_b_seq", {24'd0, b_pc_seq}, 32'h00);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1);
        check("wrap2_b_cur",  {24'd0, b_pc_cur}, 32'h00);
        check("wrap2_b_seq",  {24'd0, b_pc_seq}, 32'h01);
        check("wrap2_b_pend", {31'd0, b_pend}, 32'd0);

        // sticky flags clear only on reset
        #2 reset = 1'b1;
        #1;
        check("fin_b_ovf", {31'd0, b_ovf}, 32'd0);
        check("fin_b_unf", {31'd0, b_unf}, 32'd0);
        check("fin_b_cur", {24'd0, b_pc_cur}, 32'h00);
        reset = 1'b0;
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
